// File: rtl/present80_round_engine_if.sv
// rtl/present80_round_engine_if.sv - block handshake bundle for the PRESENT-80 round engine
// Ports (signals carried):
//   in_valid/in_ready   plaintext+key offer and acceptance
//   in_data[63:0]       plaintext, bit 63 = MSB
//   in_key[79:0]        user key, bit 79 = MSB
//   out_valid/out_ready ciphertext offer and acceptance
//   out_data[63:0]      ciphertext
//   busy                engine is working on or holding a block
interface present80_round_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [79:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/present80_round_engine.sv
// rtl/present80_round_engine.sv - iterative PRESENT-80 encryptor, one round per clock
// Modules:
//   present_sbox_4bit            single PRESENT S-box (din[3:0] -> dout[3:0])
//   present_sbox_parallel_64bit  16 nibble-wise S-boxes (din[63:0] -> dout[63:0])
//   present80_round_engine       top: clk, rst (sync, active-high), bus (slave modport:
//                                in_valid/in_ready/in_data/in_key, out_valid/out_ready/
//                                out_data, busy)

module present_sbox_4bit (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        dout = 4'h0;
        case (din)
            4'h0: dout = 4'hC;
            4'h1: dout = 4'h5;
            4'h2: dout = 4'h6;
            4'h3: dout = 4'hB;
            4'h4: dout = 4'h9;
            4'h5: dout = 4'h0;
            4'h6: dout = 4'hA;
            4'h7: dout = 4'hD;
            4'h8: dout = 4'h3;
            4'h9: dout = 4'hE;
            4'hA: dout = 4'hF;
            4'hB: dout = 4'h8;
            4'hC: dout = 4'h4;
            4'hD: dout = 4'h7;
            4'hE: dout = 4'h1;
            default: dout = 4'h2;
        endcase
    end
endmodule

module present_sbox_parallel_64bit (
    input  logic [63:0] din,
    output logic [63:0] dout
);
    for (genvar n = 0; n < 16; n++) begin : g_nib
        present_sbox_4bit u_sbox (
            .din  (din[4*n +: 4]),
            .dout (dout[4*n +: 4])
        );
    end
endmodule

module present80_round_engine #(
    parameter int NUM_ROUNDS = 31
) (
    input logic                     clk,
    input logic                     rst,
    present80_round_engine_if.slave bus
);
    localparam logic [4:0] LAST_RC = 5'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] state_reg;
    logic [79:0] key_reg;
    logic [4:0]  rc;
    logic [63:0] out_data_reg;

    logic [63:0] t;
    logic [63:0] u;
    logic [63:0] p;
    logic [79:0] k_rot;
    logic [3:0]  k_top;
    logic [79:0] k_next;
    logic        last_round;

    // Bit i moves to (16*i) mod 63; bit 63 stays in place.
    function automatic logic [63:0] player(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[(16 * i) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

    assign t = state_reg ^ key_reg[79:16];

    present_sbox_parallel_64bit u_sbox_layer (
        .din  (t),
        .dout (u)
    );

    assign p = player(u);

    // Rotate left by 61 is the same as rotate right by 19.
    assign k_rot = {key_reg[18:0], key_reg[79:19]};

    present_sbox_4bit u_key_sbox (
        .din  (k_rot[79:76]),
        .dout (k_top)
    );

    assign k_next     = {k_top, k_rot[75:20], k_rot[19:15] ^ rc, k_rot[14:0]};
    assign last_round = (rc == LAST_RC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = ROUND;
            ROUND:   if (last_round) state_next = OUT;
            OUT:     if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= '0;
            key_reg      <= '0;
            rc           <= '0;
            out_data_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg <= bus.in_data;
                        key_reg   <= bus.in_key;
                        rc        <= 5'd1;
                    end
                end
                ROUND: begin
                    state_reg <= p;
                    key_reg   <= k_next;
                    // Saturate so the counter can never wrap back into a live round.
                    if (rc != 5'd31) begin
                        rc <= rc + 5'd1;
                    end
                    // Final whitening uses the key produced in this same round.
                    if (last_round) begin
                        out_data_reg <= p ^ k_next[79:16];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == OUT);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = out_data_reg;
endmodule

// File: tb/tb_present80_round_engine.sv
// tb/tb_present80_round_engine.sv - directed known-answer bench for present80_round_engine
module tb_present80_round_engine;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    present80_round_engine_if bus();

    present80_round_engine #(.NUM_ROUNDS(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] vec_data [4];
    logic [79:0] vec_key  [4];
    logic [63:0] vec_exp  [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_known_answers();
        int cnt;
        for (int v = 0; v < 4; v++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vec_data[v];
            bus.in_key   = vec_key[v];
            step();
            bus.in_valid = 1'b0;
            bus.in_data  = ~vec_data[v];
            bus.in_key   = ~vec_key[v];
            total++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL kat%0d_busy busy=%b in_ready=%b want busy=1 in_ready=0", v, bus.busy, bus.in_ready);
            end
            cnt = 0;
            while (bus.out_valid !== 1'b1 && cnt < 100) begin
                step();
                cnt++;
            end
            total++; if (cnt != 31) begin bad++; $display("FAIL kat%0d_latency got=%0d want=31", v, cnt); end
            total++; if (bus.out_data !== vec_exp[v]) begin bad++; $display("FAIL kat%0d_data got=%h want=%h", v, bus.out_data, vec_exp[v]); end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
                bad++; $display("FAIL kat%0d_idle out_valid=%b in_ready=%b busy=%b want 0/1/0", v, bus.out_valid, bus.in_ready, bus.busy);
            end
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        int errs;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h0;
        bus.in_key   = 80'h0;
        step();
        bus.in_valid = 1'b0;
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%b want=1", bus.out_valid); end
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hFFFFFFFFFFFFFFFF;
        bus.in_key   = 80'hFFFFFFFFFFFFFFFFFFFF;
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.out_data !== 64'h5579C1387B228445 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_hold bad_cycles=%0d want=0 last_data=%h", errs, bus.out_data); end
        // in_valid still high at the handshake edge: must not be taken.
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
        end
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_stay_idle in_ready=%b want=1", bus.in_ready); end
    endtask

    task automatic test_mid_reset();
        int cnt;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h0123456789ABCDEF;
        bus.in_key   = 80'h0;
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 9; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_flags in_ready=%b out_valid=%b busy=%b want 1/0/0", bus.in_ready, bus.out_valid, bus.busy);
        end
        total++; if (bus.out_data !== 64'h0) begin bad++; $display("FAIL midrst_out_data got=%h want=0", bus.out_data); end
        cnt = 0;
        while (cnt < 40) begin
            step();
            cnt++;
            if (bus.out_valid === 1'b1) break;
        end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_output out_valid=%b want=0", bus.out_valid); end
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h0;
        bus.in_key   = 80'h0;
        step();
        bus.in_valid = 1'b0;
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
        total++; if (bus.out_data !== 64'h5579C1387B228445 || cnt != 31) begin
            bad++; $display("FAIL midrst_after got=%h lat=%0d want=5579c1387b228445 lat=31", bus.out_data, cnt);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int idx_in;
        int idx_out;
        int cyc;
        int acc_cyc [4];
        logic acc;
        idx_in  = 0;
        idx_out = 0;
        cyc     = 0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data   = vec_data[0];
        bus.in_key    = vec_key[0];
        while (idx_out < 4 && cyc < 400) begin
            acc = bus.in_ready & bus.in_valid;
            if (bus.out_valid === 1'b1) begin
                total++; if (bus.out_data !== vec_exp[idx_out]) begin
                    bad++; $display("FAIL b2b_data%0d got=%h want=%h", idx_out, bus.out_data, vec_exp[idx_out]);
                end
                idx_out++;
            end
            step();
            cyc++;
            if (acc && idx_in < 4) begin
                acc_cyc[idx_in] = cyc;
                idx_in++;
                if (idx_in < 4) begin
                    bus.in_data = vec_data[idx_in];
                    bus.in_key  = vec_key[idx_in];
                end else begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 64'h0;
                    bus.in_key   = 80'h0;
                end
            end
        end
        bus.out_ready = 1'b0;
        total++; if (idx_out != 4 || idx_in != 4) begin bad++; $display("FAIL b2b_count out=%0d in=%0d want 4/4", idx_out, idx_in); end
        if (idx_in == 4) begin
            for (int i = 0; i < 3; i++) begin
                total++; if (acc_cyc[i+1] - acc_cyc[i] != 33) begin
                    bad++; $display("FAIL b2b_spacing%0d got=%0d want=33", i, acc_cyc[i+1] - acc_cyc[i]);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 64'h0;
        bus.in_key    = 80'h0;
        bus.out_ready = 1'b0;

        vec_data[0] = 64'h0;                vec_key[0] = 80'h0;                    vec_exp[0] = 64'h5579C1387B228445;
        vec_data[1] = 64'h0;                vec_key[1] = 80'hFFFFFFFFFFFFFFFFFFFF; vec_exp[1] = 64'hE72C46C0F5945049;
        vec_data[2] = 64'hFFFFFFFFFFFFFFFF; vec_key[2] = 80'h0;                    vec_exp[2] = 64'hA112FFC72F68417B;
        vec_data[3] = 64'hFFFFFFFFFFFFFFFF; vec_key[3] = 80'hFFFFFFFFFFFFFFFFFFFF; vec_exp[3] = 64'h3333DCD3213210D2;

        test_reset();
        test_known_answers();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
